testbench_ls_input_conditioner: RTL and testbench

Conditions the raw, asynchronous discrete inputs of the low-speed testbench before they reach the 8-bit input PIO port: per-bit two-flop synchronization, counter-based debounce and sticky edge capture. The debounced level bus drives the PIO `in_port` directly. Edge flags and a combined interrupt let software detect short-lived events between PIO polls.

---
 rtl/testbench_ls_input_conditioner.sv | 79 +++++++
 tb/tb_testbench_ls_input_conditioner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testbench_ls_input_conditioner.sv
// Input conditioner for the low-speed testbench discrete inputs.
// Each bit is two-flop synchronized, debounced by a per-bit stability
// counter, and any accepted level change sets a sticky edge flag. The
// masked OR of the flags is presented as a registered interrupt.
module testbench_ls_input_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] edge_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] edge_flags,
  output logic             irq
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_in_port;
  logic [WIDTH-1:0] r_edge_flags;
  logic             r_irq;

  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_in_next;
  logic [WIDTH-1:0] w_change;
  logic [WIDTH-1:0] w_flags_next;

  // Per-bit debounce decision; a change is flagged on the same edge the level updates.
  always_comb begin
    w_cnt_next = r_cnt;
    w_in_next  = r_in_port;
    w_change   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] == r_in_port[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_TERM) begin
        w_in_next[i]  = r_sync2[i];
        w_cnt_next[i] = '0;
        w_change[i]   = 1'b1;
      end else begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
    // Set has priority over clear so no accepted event is lost.
    w_flags_next = w_change | (r_edge_flags & ~edge_clear);
  end

  // Synchronizer, debounce state, sticky flags and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_in_port    <= '0;
      r_edge_flags <= '0;
      r_irq        <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1      <= raw_in;
      r_sync2      <= r_sync1;
      r_in_port    <= w_in_next;
      r_edge_flags <= w_flags_next;
      r_irq        <= |(w_flags_next & irq_mask);
      r_cnt        <= w_cnt_next;
    end
  end

  assign in_port    = r_in_port;
  assign edge_flags = r_edge_flags;
  assign irq        = r_irq;

endmodule

// File: tb/tb_testbench_ls_input_conditioner.sv
// Self-checking bench for testbench_ls_input_conditioner.
// A reference model accepts a new level when the last D synchronized
// samples all differ from the current level; directed scenarios check
// exact latencies against constants.
module tb_testbench_ls_input_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] edge_clear;
  logic [W-1:0] irq_mask;
  logic [W-1:0] in_port;
  logic [W-1:0] edge_flags;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  testbench_ls_input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .edge_clear(edge_clear),
    .irq_mask  (irq_mask),
    .in_port   (in_port),
    .edge_flags(edge_flags),
    .irq       (irq)
  );

  // Reference model: two-stage delay of raw_in, then a sliding window of
  // the last D synchronized samples; all D differing from the level flips it.
  logic [W-1:0] m_s1, m_s2, m_level, m_flags, m_chg, m_fnext;
  logic         m_irq;
  logic [W-1:0] m_hist [D-1];
  int           m_nv;

  always_comb begin
    m_chg = '1;
    if (m_nv < D - 1) m_chg = '0;
    for (int b = 0; b < W; b++) begin
      if (m_s2[b] == m_level[b]) m_chg[b] = 1'b0;
      for (int j = 0; j < D - 1; j++)
        if (m_hist[j][b] == m_level[b]) m_chg[b] = 1'b0;
    end
    m_fnext = m_chg | (m_flags & ~edge_clear);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_level <= '0;
      m_flags <= '0;
      m_irq   <= 1'b0;
      m_nv    <= 0;
    end else begin
      m_hist[0] <= m_s2;
      for (int j = 1; j < D - 1; j++) m_hist[j] <= m_hist[j-1];
      if (m_nv < D - 1) m_nv <= m_nv + 1;
      m_level <= m_level ^ m_chg;
      m_flags <= m_fnext;
      m_irq   <= |(m_fnext & irq_mask);
      m_s2    <= m_s1;
      m_s1    <= raw_in;
    end
  end

  // One active edge, then return to the falling edge for checks/drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a level long enough to be accepted, then clear all flags.
  task automatic settle(input logic [W-1:0] v);
    raw_in = v;
    repeat (D + 4) tick();
    edge_clear = '1;
    tick();
    edge_clear = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    reset  = 1'b1;
    raw_in = 8'hFF;
    repeat (3) tick();
    n_checks++;
    if (in_port !== 8'h00 || edge_flags !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state in_port=%h flags=%h irq=%b required 00/00/0", in_port, edge_flags, irq);
    end
    reset = 1'b0;
    for (int k = 1; k <= D + 2; k++) begin
      tick();
      exp = (k == D + 2) ? 8'hFF : 8'h00;
      n_checks++;
      if (in_port !== exp || edge_flags !== exp) begin
        n_fail++;
        $display("FAIL reset_accept edge=%0d in_port=%h flags=%h required %h", k, in_port, edge_flags, exp);
      end
    end
    settle(8'h00);
    n_checks++;
    if (in_port !== 8'h00 || edge_flags !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_settle in_port=%h flags=%h required 00/00", in_port, edge_flags);
    end
  endtask

  task automatic test_glitch();
    logic exp;
    raw_in = 8'h04;
    repeat (3) tick();
    raw_in = 8'h00;
    repeat (D + 4) begin
      tick();
      n_checks++;
      if (in_port !== 8'h00 || edge_flags !== 8'h00) begin
        n_fail++;
        $display("FAIL glitch_reject in_port=%h flags=%h required 00/00", in_port, edge_flags);
      end
    end
    raw_in = 8'h04;
    for (int k = 0; k <= D + 1; k++) begin
      tick();
      if (k == D - 1) raw_in = 8'h00;
      exp = (k == D + 1);
      n_checks++;
      if (in_port[2] !== exp || edge_flags[2] !== exp) begin
        n_fail++;
        $display("FAIL glitch_accept edge=N+%0d in_port[2]=%b flags[2]=%b required %b", k, in_port[2], edge_flags[2], exp);
      end
    end
    settle(8'h00);
  endtask

  task automatic test_bouncy();
    logic [3:0] seq = 4'b0101;
    int sets = 0;
    int moves = 0;
    logic pf, pi;
    pf = edge_flags[5];
    pi = in_port[5];
    for (int k = 3; k >= 0; k--) begin
      raw_in = {2'b00, ~seq[k], 5'b00000};
      tick();
      if (!pf && edge_flags[5]) sets++;
      if (pi !== in_port[5]) moves++;
      pf = edge_flags[5];
      pi = in_port[5];
    end
    raw_in = 8'h20;
    for (int k = 0; k <= D + 4; k++) begin
      tick();
      if (!pf && edge_flags[5]) sets++;
      if (pi !== in_port[5]) moves++;
      pf = edge_flags[5];
      pi = in_port[5];
      if (k <= D + 1) begin
        n_checks++;
        if (in_port[5] !== (k == D + 1 ? 1'b1 : (k < D + 1 ? 1'b0 : 1'b1))) begin
          n_fail++;
          $display("FAIL bouncy_timing edge=N+%0d in_port[5]=%b required %b", k, in_port[5], (k == D + 1));
        end
      end
    end
    n_checks++;
    if (sets !== 1 || moves !== 1) begin
      n_fail++;
      $display("FAIL bouncy_once flag_sets=%0d level_moves=%0d required 1/1", sets, moves);
    end
    settle(8'h00);
  endtask

  task automatic test_collision();
    raw_in = 8'h01;
    for (int k = 0; k <= D; k++) tick();
    edge_clear = 8'h01;
    tick();
    n_checks++;
    if (in_port[0] !== 1'b1 || edge_flags[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_set_wins in_port[0]=%b flags[0]=%b required 1/1", in_port[0], edge_flags[0]);
    end
    tick();
    edge_clear = 8'h00;
    n_checks++;
    if (edge_flags[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_clear flags[0]=%b required 0", edge_flags[0]);
    end
  endtask

  task automatic test_irq_mask();
    irq_mask = 8'h01;
    raw_in   = 8'h09;
    repeat (D + 2) tick();
    n_checks++;
    if (edge_flags !== 8'h08 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked flags=%h irq=%b required 08/0", edge_flags, irq);
    end
    irq_mask = 8'h08;
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_unmask irq=%b required 1", irq);
    end
    edge_clear = 8'h08;
    tick();
    edge_clear = 8'h00;
    n_checks++;
    if (irq !== 1'b0 || edge_flags !== 8'h00) begin
      n_fail++;
      $display("FAIL irq_clear irq=%b flags=%h required 0/00", irq, edge_flags);
    end
    irq_mask = 8'h00;
  endtask

  task automatic test_reset_midcount();
    logic [W-1:0] exp;
    raw_in = 8'h0B;
    repeat (D) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (in_port !== 8'h00) begin
      n_fail++;
      $display("FAIL midcount_reset in_port=%h required 00", in_port);
    end
    for (int k = 1; k <= D + 2; k++) begin
      tick();
      exp = (k == D + 2) ? 8'h0B : 8'h00;
      n_checks++;
      if (in_port !== exp) begin
        n_fail++;
        $display("FAIL midcount_accept edge=%0d in_port=%h required %h", k, in_port, exp);
      end
    end
    settle(8'h00);
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 80; s++) begin
      raw_in = W'($urandom);
      len    = $urandom_range(1, 8);
      if ($urandom_range(0, 3) == 0) irq_mask = W'($urandom);
      for (int c = 0; c < len; c++) begin
        edge_clear = W'($urandom & $urandom & $urandom);
        reset      = ($urandom_range(0, 59) == 0);
        tick();
        n_checks++;
        if (in_port !== m_level || edge_flags !== m_flags || irq !== m_irq) begin
          n_fail++;
          $display("FAIL random_model seg=%0d in_port=%h flags=%h irq=%b required %h/%h/%b",
                   s, in_port, edge_flags, irq, m_level, m_flags, m_irq);
        end
      end
    end
    reset      = 1'b0;
    edge_clear = '0;
  endtask

  initial begin
    reset      = 1'b1;
    raw_in     = '0;
    edge_clear = '0;
    irq_mask   = '0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_bouncy();
    test_collision();
    test_irq_mask();
    test_reset_midcount();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
